ram_sync_pipe: RTL and testbench
================================

Name: ram_sync_pipe

Overview:
Parametrised, byte-enabled, single-port data RAM with a valid/ready request channel and a valid/ready response channel. Read latency is configurable, and responses are buffered so back-pressure never loses data. Sits behind the BIU as the data-memory target and replaces the combinational-read RAM. Adds address-range and alignment checking with an error response.

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 8; BE_W = DATA_W/8.
ADDR_W, 32, byte-address width.
DEPTH, 1024, number of DATA_W words; must be a power of two.
RD_LAT, 1, cycles from request accept to earliest rsp_valid; legal range 1..4.
BASE_ADDR, 0, byte address of word 0; must be DEPTH*BE_W aligned.

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  reset, synchronous, active-high.
req_valid  in  1  request present.
req_ready  out  1  request can be accepted.
req_we  in  1  1 = write, 0 = read.
req_addr  in  ADDR_W  byte address.
req_be  in  BE_W  byte lane enables, write only; bit i selects bits [8i+7:8i].
req_wdata  in  DATA_W  write data.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer accepts response.
rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
rsp_err  out  1  response is an error.
par_inj  in  1  only when RAM_PARITY_EN is defined: corrupt parity on this write.

Behaviour:
- Reset (rst=1 at an edge):
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Latency pipeline and response FIFO are flushed; the outstanding counter is 0.
  - req_ready=0 while rst=1, and 1 in the first cycle after rst deasserts.
  - Memory contents are not reset.
  - Reset mid-transaction drops all in-flight responses and performs no pending write.
- Accept condition: req_valid & req_ready at a rising edge. At most one request per cycle.
- Decode:
  - off = req_addr - BASE_ADDR, computed in ADDR_W bits, unsigned.
  - idx = off >> log2(BE_W).
  - Error if off[log2(BE_W)-1:0] != 0 (misaligned) or off >= DEPTH*BE_W (covers addr < BASE_ADDR through wrap).
- Write, no error:
  - Each lane with req_be[i]=1 is written at the accept edge; other lanes are unchanged.
  - req_be=0 is a legal no-op.
  - A response is still generated: rdata=0, err=0.
- Read, no error: the word at idx is sampled at the accept edge. A read accepted the cycle after a write to the same idx returns the new data.
- Error: memory is untouched; the response has rdata=0 and err=1.
- Latency pipeline: RD_LAT stages. The response enters the response FIFO RD_LAT-1 cycles after accept, so it can appear on rsp_valid exactly RD_LAT cycles after the accept edge when the FIFO is empty and rsp_ready=1.
- Response FIFO:
  - Depth RD_LAT+1.
  - Head drives rsp_valid/rsp_rdata/rsp_err, which are held stable while rsp_valid=1 and rsp_ready=0.
  - Pop on rsp_valid & rsp_ready.
- Flow control:
  - outstanding = in-pipeline count + FIFO count.
  - req_ready = (outstanding < RD_LAT+1), computed from registered state only (no combinational path from req_valid or rsp_ready).
  - An accept and a pop in the same cycle leave outstanding unchanged.
  - FIFO overflow is therefore impossible. With rsp_ready held at 1, full throughput is 1 request per cycle.
- Responses are returned in request order. There is no ID field.

Optional Feature:
RAM_PARITY_EN:
- Defined:
  - One even-parity bit is stored per byte lane and updated with that lane's write.
  - If par_inj=1 on an accepted write, the stored parity of every enabled lane is inverted.
  - A read whose stored parity mismatches in any lane returns err=1 with the actual stored data on rsp_rdata, not zeroed.
  - Lanes never written have undefined parity; software initialises memory before use.
- Not defined: no parity storage, no par_inj port, and rsp_err reports decode errors only.

Test Plan:
- Reset then idle: hold rst=1 for 3 cycles -> req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0; the cycle after release req_ready=1.
- Byte-enable merge, RD_LAT=2: write 0x11223344 be=4'hF to addr 0x10, write 0xAABBCCDD be=4'b0101 to 0x10, read 0x10 -> two write responses (0, err=0), then a read response 0x11BB33DD exactly 2 cycles after the read accept.
- Back-pressure, RD_LAT=1: issue 4 back-to-back reads of distinct words with rsp_ready=0 -> req_ready drops after 2 accepts, rsp_valid/rsp_rdata stay stable; raise rsp_ready -> all 4 responses arrive in order, none lost or duplicated.
- Errors, BASE_ADDR=0x1000, DEPTH=1024: read 0x0FFC, read 0x2000, write 0x1002 -> each returns err=1, rdata=0; a subsequent read of 0x1000 shows unchanged contents.
- Reset mid-stream: accept 2 reads, assert rst before their responses -> no rsp_valid after reset; the next read returns correct data with latency RD_LAT.
- RAM_PARITY_EN: write 0xDEADBEEF be=4'hF with par_inj=1 to 0x20, then read 0x20 -> err=1, rdata=0xDEADBEEF; rewrite with par_inj=0 and read again -> err=0.

Source files
------------

// File: rtl/ram_sync_pipe.sv
// ram_sync_pipe: byte-enabled single-port RAM with valid/ready request and response channels, configurable read latency and a response FIFO.
// Optional per-lane even parity is enabled by defining RAM_PARITY_EN.
module ram_sync_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH = 1024,
  parameter int RD_LAT = 1,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W/8-1:0]    req_be,
  input  logic [DATA_W-1:0]      req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err
`ifdef RAM_PARITY_EN
  , input logic                  par_inj
`endif
);
  localparam int BE_W = DATA_W / 8;
  localparam int IW = $clog2(DEPTH);
  localparam int OB = $clog2(BE_W);
  localparam int F = RD_LAT + 1;
  localparam int PW = $clog2(F);
  localparam int CW = $clog2(F + 1);
  localparam int RW = DATA_W + 1;
  localparam int PL = RD_LAT - 1;
  localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(DEPTH * BE_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] off;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] rd;
  logic              bad, acc, wr, push, pop;
  logic [RW-1:0]     a_r, t_r;
  logic [RW-1:0]     fifo [F];
  logic [PW-1:0]     wp, rp;
  logic [CW-1:0]     cnt, outs;

  assign off = req_addr - BASE_ADDR;
  assign bad = (|(off & ADDR_W'(BE_W - 1))) || (off >= SPAN);
  assign idx = IW'(off >> OB);
  assign rd = mem[idx];
  assign req_ready = ~rst & (outs < CW'(F));
  assign acc = req_valid & req_ready;
  assign wr = acc & req_we & ~bad;
  assign rsp_valid = cnt != '0;
  assign pop = rsp_valid & rsp_ready;
  assign {rsp_err, rsp_rdata} = rsp_valid ? fifo[rp] : '0;

`ifdef RAM_PARITY_EN
  logic [BE_W-1:0] par [DEPTH];
  logic [BE_W-1:0] rpar, wpar;
  always_comb begin
    rpar = '0;
    wpar = '0;
    for (int i = 0; i < BE_W; i++) begin
      rpar[i] = ^rd[8*i +: 8];
      wpar[i] = ^req_wdata[8*i +: 8] ^ par_inj;
    end
  end
  // A parity error still returns the stored word so software can inspect it.
  assign a_r = bad ? {1'b1, {DATA_W{1'b0}}} : req_we ? '0 : {|(rpar ^ par[idx]), rd};
  always_ff @(posedge clk)
    if (wr)
      for (int i = 0; i < BE_W; i++)
        if (req_be[i]) par[idx][i] <= wpar[i];
`else
  assign a_r = (bad | req_we) ? {bad, {DATA_W{1'b0}}} : {1'b0, rd};
`endif

  always_ff @(posedge clk)
    if (wr)
      for (int i = 0; i < BE_W; i++)
        if (req_be[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];

  // The FIFO write is the last latency stage, so only RD_LAT-1 register stages sit in front of it.
  if (RD_LAT == 1) begin : g_direct
    assign push = acc;
    assign t_r = a_r;
  end else begin : g_pipe
    logic [PL-1:0] pv;
    logic [RW-1:0] pr [PL];
    always_ff @(posedge clk) begin
      pv <= rst ? '0 : (pv << 1) | PL'(acc);
      pr[0] <= a_r;
      for (int k = 1; k < PL; k++) pr[k] <= pr[k-1];
    end
    assign push = pv[PL-1];
    assign t_r = pr[PL-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      outs <= '0;
    end else begin
      if (push) begin
        fifo[wp] <= t_r;
        wp <= (wp == PW'(RD_LAT)) ? '0 : wp + 1'b1;
      end
      if (pop) rp <= (rp == PW'(RD_LAT)) ? '0 : rp + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
      outs <= outs + CW'(acc) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_ram_sync_pipe.sv
// tb_ram_sync_pipe: directed bench for ram_sync_pipe with RD_LAT=2 and RD_LAT=1 instances at BASE_ADDR 0x1000.
module tb_ram_sync_pipe;
  logic clk = 0, rst = 1, vld = 0, sel = 0, rr = 1, we = 0, par_inj = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [3:0] be = 0;
  logic rdy0, rdy1, rv0, rv1, re0, re1, rdy, rv, re;
  logic [31:0] rd0, rd1, rd;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  assign rdy = sel ? rdy1 : rdy0;
  assign rv = sel ? rv1 : rv0;
  assign rd = sel ? rd1 : rd0;
  assign re = sel ? re1 : re0;

  ram_sync_pipe #(.RD_LAT(2), .BASE_ADDR(32'h1000)) d0 (
`ifdef RAM_PARITY_EN
    .par_inj(par_inj),
`endif
    .clk(clk), .rst(rst), .req_valid(vld & ~sel), .req_ready(rdy0), .req_we(we),
    .req_addr(addr), .req_be(be), .req_wdata(wdata), .rsp_valid(rv0),
    .rsp_ready(sel | rr), .rsp_rdata(rd0), .rsp_err(re0));

  ram_sync_pipe #(.RD_LAT(1), .BASE_ADDR(32'h1000)) d1 (
`ifdef RAM_PARITY_EN
    .par_inj(par_inj),
`endif
    .clk(clk), .rst(rst), .req_valid(vld & sel), .req_ready(rdy1), .req_we(we),
    .req_addr(addr), .req_be(be), .req_wdata(wdata), .rsp_valid(rv1),
    .rsp_ready(~sel | rr), .rsp_rdata(rd1), .rsp_err(re1));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    int n = 0;
    we = w; addr = a; be = b; wdata = d; vld = 1;
    while (!rdy && n < 20) begin @(posedge clk); #1; n++; end
    chk("accept_wait", n < 20, 1);
    @(posedge clk); #1;
    vld = 0;
  endtask

  task automatic resp(input string tag, input logic [31:0] ed, input logic ee);
    int lat = 1;
    while (!rv && lat < 20) begin @(posedge clk); #1; lat++; end
    chk({tag, "_lat"}, lat, sel ? 1 : 2);
    chk({tag, "_data"}, rd, ed);
    chk({tag, "_err"}, re, ee);
    @(posedge clk); #1;
  endtask

  initial begin
    int acc_n, got, cyc;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready0", rdy0, 0);
    chk("rst_ready1", rdy1, 0);
    chk("rst_valid", rv0, 0);
    chk("rst_rdata", rd0, 0);
    chk("rst_err", re0, 0);
    rst = 0;
    #1;
    chk("ready_after_rst0", rdy0, 1);
    chk("ready_after_rst1", rdy1, 1);
    issue(1, 32'h1010, 4'hF, 32'h11223344); resp("wr1", 0, 0);
    issue(1, 32'h1010, 4'h5, 32'hAABBCCDD); resp("wr2", 0, 0);
    issue(0, 32'h1010, 4'h0, 0); resp("merge", 32'h11BB33DD, 0);
    issue(1, 32'h1010, 4'h0, 32'hFFFFFFFF); resp("nop_wr", 0, 0);
    issue(0, 32'h1010, 4'h0, 0); resp("nop_rd", 32'h11BB33DD, 0);
    we = 1; addr = 32'h1014; be = 4'hF; wdata = 32'hCAFEF00D; vld = 1;
    @(posedge clk); #1;
    we = 0;
    @(posedge clk); #1;
    vld = 0;
    chk("raw_wr_valid", rv0, 1);
    chk("raw_wr_data", rd0, 0);
    chk("raw_wr_err", re0, 0);
    @(posedge clk); #1;
    chk("raw_rd_valid", rv0, 1);
    chk("raw_rd_data", rd0, 32'hCAFEF00D);
    @(posedge clk); #1;
    chk("raw_idle", rv0, 0);
    issue(1, 32'h1000, 4'hF, 32'h55667788); resp("w_base", 0, 0);
    issue(1, 32'h1FFC, 4'hF, 32'h0BADCAFE); resp("w_top", 0, 0);
    issue(0, 32'h0FFC, 4'h0, 0); resp("e_low", 0, 1);
    issue(0, 32'h2000, 4'h0, 0); resp("e_high", 0, 1);
    issue(1, 32'h1002, 4'hF, 32'hFFFFFFFF); resp("e_mis", 0, 1);
    issue(0, 32'h1000, 4'h0, 0); resp("base_kept", 32'h55667788, 0);
    issue(0, 32'h1FFC, 4'h0, 0); resp("top", 32'h0BADCAFE, 0);
    sel = 1;
    for (int i = 0; i < 4; i++) begin
      issue(1, 32'h1040 + 4 * i, 4'hF, 32'hC0DE0000 + i);
      resp("bp_wr", 0, 0);
    end
    rr = 0; we = 0; addr = 32'h1040; vld = 1; acc_n = 0;
    for (int c = 0; c < 6; c++) begin
      if (vld && rdy) acc_n++;
      if (c >= 2) chk("bp_hold", rd, 32'hC0DE0000);
      @(posedge clk); #1;
      addr = 32'h1040 + 4 * acc_n;
      vld = acc_n < 4;
    end
    chk("bp_accepts", acc_n, 2);
    chk("bp_ready_low", rdy, 0);
    chk("bp_valid", rv, 1);
    rr = 1; got = 0; cyc = 0;
    while (got < 4 && cyc < 30) begin
      if (vld && rdy) acc_n++;
      if (rv) begin
        chk("bp_order", rd, 32'hC0DE0000 + got);
        got++;
      end
      @(posedge clk); #1;
      addr = 32'h1040 + 4 * acc_n;
      vld = acc_n < 4;
      cyc++;
    end
    vld = 0;
    chk("bp_count", got, 4);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_dup", rv, 0);
    chk("bp_ready_back", rdy, 1);
    sel = 0; rr = 0; we = 0; addr = 32'h1000; vld = 1;
    @(posedge clk); #1;
    addr = 32'h1FFC;
    @(posedge clk); #1;
    vld = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0; rr = 1;
    for (int c = 0; c < 5; c++) begin
      chk("rst_drop", rv0, 0);
      @(posedge clk); #1;
    end
    issue(0, 32'h1FFC, 4'h0, 0); resp("post_rst", 32'h0BADCAFE, 0);
`ifdef RAM_PARITY_EN
    par_inj = 1;
    issue(1, 32'h1020, 4'hF, 32'hDEADBEEF);
    par_inj = 0;
    resp("p_wr", 0, 0);
    issue(0, 32'h1020, 4'h0, 0); resp("p_bad", 32'hDEADBEEF, 1);
    issue(1, 32'h1020, 4'hF, 32'hDEADBEEF); resp("p_rw", 0, 0);
    issue(0, 32'h1020, 4'h0, 0); resp("p_ok", 32'hDEADBEEF, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
